fml_arb2: RTL and testbench
===========================

Name: fml_arb2

Overview:
- Two-master FML arbiter that shares one FML slave (the BRAM-backed FML memory) between two requesters.
- Round-robin arbitration on command phase; grant locked through the burst data phase so write data/sel come from the owning master.
- Sits between two FML masters (e.g. CPU bridge and DMA) and the single FML memory port.

Parameters:
- adr_width, 15, FML byte address width, identical on masters and slave.
- data_cycles, 4'd8, cycles grant is held after slave eack to cover write delay + burst (must be >= 1).

Ports:
- sys_clk  in  1  system clock, all logic on rising edge.
- sys_rst  in  1  reset, asynchronous, active-high.
- m0_adr  in  adr_width  master 0 address.
- m0_stb  in  1  master 0 request, held until m0_eack.
- m0_we  in  1  master 0 write.
- m0_eack  out  1  master 0 acknowledge, one cycle.
- m0_sel  in  8  master 0 byte enables.
- m0_di  in  64  master 0 write data.
- m0_do  out  64  read data to master 0.
- m1_adr, m1_stb, m1_we, m1_eack, m1_sel, m1_di, m1_do: same as m0_* for master 1.
- s_adr  out  adr_width  slave address.
- s_stb  out  1  slave request.
- s_we  out  1  slave write.
- s_eack  in  1  slave acknowledge.
- s_sel  out  8  slave byte enables.
- s_di  out  64  slave write data.
- s_do  in  64  slave read data.

Behaviour:
- Reset (async): state IDLE, grant=0, last=1 (master 0 wins first tie), counter=0; s_stb=0, m0_eack=m1_eack=0, s_sel=0, s_di=0, s_adr=0, s_we=0.
- States: IDLE, CMD, DATA; 2-bit encoding.
- IDLE: no stb -> stay. Only one stb -> register grant to it. Both -> grant = ~last. Next state CMD. Arbitration costs exactly 1 cycle.
- CMD: s_stb = stb of granted master; s_adr/s_we = granted master's. s_eack routed combinationally to granted master's eack only; other eack=0.
- CMD, s_eack=1 -> DATA, counter <= data_cycles-1, last <= grant.
- CMD, granted stb dropped before eack (protocol violation) -> IDLE, last unchanged, s_stb=0 that cycle.
- DATA: s_stb=0; s_sel/s_di muxed from granted master; counter decrements each cycle; counter==0 -> IDLE.
- s_sel=0 and s_di=0 in IDLE; in CMD muxed from granted master (first write beat may coincide with eack).
- m0_do = m1_do = s_do always (broadcast); masters qualify by their own eack.
- Starvation: master streaming back-to-back cannot win twice while other stb is high at the IDLE decision.
- Minimum transaction spacing: 1 (IDLE) + CMD cycles + data_cycles.
- Async reset mid-CMD or mid-DATA: s_stb and eacks drop immediately; in-flight burst abandoned.

Optional Feature:
- Macro FML_ARB2_STATS_EN.
- Defined: extra outputs m0_grants, m1_grants (16-bit each). Increment on eack of that master, saturate at 16'hFFFF, clear on sys_rst.
- Undefined: ports and counters absent; arbitration timing identical.

Decomposition:
- Package fml_arb_pkg: state encoding localparams (IDLE/CMD/DATA), FML_DW=64, FML_SW=8.
- Sub-module fml_arb_rr: combinational 2-way round-robin picker (req[1:0], last -> grant, valid), reused for wider arbiters.

Test Plan:
- Single read: m0_stb, adr=15'h0100, we=0; slave eacks 2 cycles after s_stb -> m0_eack 1 cycle, s_adr=15'h0100, returns to IDLE after 8 DATA cycles; m1_eack never set.
- Simultaneous after reset: m0_stb and m1_stb together -> m0 served first, then m1; s_adr order 0x0100 then 0x0200.
- Fairness: m0 re-requests immediately after each eack while m1 holds stb -> grants alternate m0, m1, m0, m1 over 4 transactions.
- Write data routing: m1 write, sel=8'h0F, di=64'hDEADBEEF_CAFEF00D during DATA, m0 driving di=0 -> s_di/s_sel show m1 values for all 8 DATA cycles.
- Reset mid-DATA: assert sys_rst at DATA cycle 3 -> s_stb=0 and eacks=0 same cycle; first request after release served, m0 winning a tie.
- With FML_ARB2_STATS_EN: 3 m0 and 2 m1 transactions -> m0_grants=3, m1_grants=2; force m0_grants to 16'hFFFF, one more m0 transaction -> stays 16'hFFFF.

Source files
------------

// File: rtl/fml_arb_pkg.sv
// Shared constants and state encoding for the FML arbiters.
package fml_arb_pkg;

  localparam int FML_DW = 64;
  localparam int FML_SW = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CMD  = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    CMD  = ST_CMD,
    DATA = ST_DATA
  } state_t;

endpackage

// File: rtl/fml_arb_rr.sv
// Combinational 2-way round-robin picker: on a tie the master that did not win last time gets the grant.
module fml_arb_rr (
  input  logic [1:0] req,
  input  logic       last,
  output logic       grant,
  output logic       valid
);

  assign valid = |req;
  assign grant = (req == 2'b11) ? ~last : req[1];

endmodule

// File: rtl/fml_arb2.sv
// Two-master FML arbiter: round-robin on the command phase, grant held through the burst.
// Optional per-master grant counters are built when FML_ARB2_STATS_EN is defined.
module fml_arb2
  import fml_arb_pkg::*;
#(
  parameter int         adr_width   = 15,
  parameter logic [3:0] data_cycles = 4'd8
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic [adr_width-1:0] m0_adr,
  input  logic                 m0_stb,
  input  logic                 m0_we,
  output logic                 m0_eack,
  input  logic [FML_SW-1:0]    m0_sel,
  input  logic [FML_DW-1:0]    m0_di,
  output logic [FML_DW-1:0]    m0_do,
  input  logic [adr_width-1:0] m1_adr,
  input  logic                 m1_stb,
  input  logic                 m1_we,
  output logic                 m1_eack,
  input  logic [FML_SW-1:0]    m1_sel,
  input  logic [FML_DW-1:0]    m1_di,
  output logic [FML_DW-1:0]    m1_do,
  output logic [adr_width-1:0] s_adr,
  output logic                 s_stb,
  output logic                 s_we,
  input  logic                 s_eack,
  output logic [FML_SW-1:0]    s_sel,
  output logic [FML_DW-1:0]    s_di,
  input  logic [FML_DW-1:0]    s_do,
`ifdef FML_ARB2_STATS_EN
  output logic [15:0]          m0_grants,
  output logic [15:0]          m1_grants,
`endif
  output state_t               fsm_state
);

  state_t     state_q, state_d;
  logic       grant_q, grant_d;
  logic       last_q, last_d;
  logic [3:0] cnt_q, cnt_d;
  logic       rr_grant, rr_valid;

  logic                 g_stb, g_we;
  logic [adr_width-1:0] g_adr;
  logic [FML_SW-1:0]    g_sel;
  logic [FML_DW-1:0]    g_di;

  fml_arb_rr u_rr (
    .req   ({m1_stb, m0_stb}),
    .last  (last_q),
    .grant (rr_grant),
    .valid (rr_valid)
  );

  assign g_stb = grant_q ? m1_stb : m0_stb;
  assign g_we  = grant_q ? m1_we  : m0_we;
  assign g_adr = grant_q ? m1_adr : m0_adr;
  assign g_sel = grant_q ? m1_sel : m0_sel;
  assign g_di  = grant_q ? m1_di  : m0_di;

  // Read data is broadcast; each master qualifies it with its own eack.
  assign m0_do     = s_do;
  assign m1_do     = s_do;
  assign fsm_state = state_q;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= IDLE;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    s_stb   = 1'b0;
    s_adr   = '0;
    s_we    = 1'b0;
    s_sel   = '0;
    s_di    = '0;
    m0_eack = 1'b0;
    m1_eack = 1'b0;
    case (state_q)
      IDLE: begin
        if (rr_valid) begin
          grant_d = rr_grant;
          state_d = CMD;
        end
      end
      CMD: begin
        s_adr = g_adr;
        s_we  = g_we;
        s_sel = g_sel;
        s_di  = g_di;
        // A master withdrawing its request mid-command is abandoned without touching fairness.
        if (!g_stb) begin
          state_d = IDLE;
        end else begin
          s_stb   = 1'b1;
          m0_eack = s_eack & ~grant_q;
          m1_eack = s_eack & grant_q;
          if (s_eack) begin
            state_d = DATA;
            cnt_d   = 4'(data_cycles - 4'd1);
            last_d  = grant_q;
          end
        end
      end
      DATA: begin
        s_adr = g_adr;
        s_we  = g_we;
        s_sel = g_sel;
        s_di  = g_di;
        if (cnt_q == 4'd0) state_d = IDLE;
        else cnt_d = cnt_q - 4'd1;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef FML_ARB2_STATS_EN
  logic [15:0] m0_cnt, m1_cnt;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      m0_cnt <= 16'd0;
      m1_cnt <= 16'd0;
    end else begin
      if (m0_eack && m0_cnt != 16'hFFFF) m0_cnt <= m0_cnt + 16'd1;
      if (m1_eack && m1_cnt != 16'hFFFF) m1_cnt <= m1_cnt + 16'd1;
    end
  end

  assign m0_grants = m0_cnt;
  assign m1_grants = m1_cnt;
`endif

endmodule

// File: tb/tb_fml_arb2.sv
// Directed bench for fml_arb2: a table of arbitration vectors plus hand-written reset,
// protocol-violation and (with FML_ARB2_STATS_EN) grant-counter sequences.
module tb_fml_arb2;
  import fml_arb_pkg::*;

  localparam int AW = 15;
  localparam int DC = 8;

  logic          sys_clk = 1'b0;
  logic          sys_rst = 1'b1;
  logic [AW-1:0] m0_adr = 15'h0100, m1_adr = 15'h0200;
  logic          m0_stb = 1'b0, m1_stb = 1'b0, m0_we = 1'b0, m1_we = 1'b0;
  logic          m0_eack, m1_eack;
  logic [7:0]    m0_sel = '0, m1_sel = '0;
  logic [63:0]   m0_di = '0, m1_di = '0, m0_do, m1_do;
  logic [AW-1:0] s_adr;
  logic          s_stb, s_we;
  logic          s_eack = 1'b0;
  logic [7:0]    s_sel;
  logic [63:0]   s_di;
  logic [63:0]   s_do = '0;
  state_t        fsm_state;
`ifdef FML_ARB2_STATS_EN
  logic [15:0]   m0_grants, m1_grants;
`endif

  int tests = 0;
  int fails = 0;
  int exp_g0 = 0;
  int exp_g1 = 0;

  fml_arb2 #(.adr_width(AW), .data_cycles(4'd8)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .m0_adr(m0_adr), .m0_stb(m0_stb), .m0_we(m0_we), .m0_eack(m0_eack),
    .m0_sel(m0_sel), .m0_di(m0_di), .m0_do(m0_do),
    .m1_adr(m1_adr), .m1_stb(m1_stb), .m1_we(m1_we), .m1_eack(m1_eack),
    .m1_sel(m1_sel), .m1_di(m1_di), .m1_do(m1_do),
    .s_adr(s_adr), .s_stb(s_stb), .s_we(s_we), .s_eack(s_eack),
    .s_sel(s_sel), .s_di(s_di), .s_do(s_do),
`ifdef FML_ARB2_STATS_EN
    .m0_grants(m0_grants), .m1_grants(m1_grants),
`endif
    .fsm_state(fsm_state)
  );

  // clock / reset
  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [1:0]  req;
    logic        exp_g;
    logic        m0_we;
    logic [7:0]  m0_sel;
    logic [63:0] m0_di;
    logic        m1_we;
    logic [7:0]  m1_sel;
    logic [63:0] m1_di;
    int          dly;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] req, input logic g, input int dly);
    vec_t v;
    v = '{req, g, 1'b0, 8'h00, 64'h0, 1'b0, 8'h00, 64'h0, dly};
    return v;
  endfunction

  // driver: from IDLE, arbitrate, run the command phase and take the eack edge
  task automatic do_cmd(input vec_t v);
    logic [AW-1:0] e_adr;
    logic [7:0]    e_sel;
    logic [63:0]   e_di;
    logic          e_we;
    e_adr = v.exp_g ? 15'h0200 : 15'h0100;
    e_sel = v.exp_g ? v.m1_sel : v.m0_sel;
    e_di  = v.exp_g ? v.m1_di  : v.m0_di;
    e_we  = v.exp_g ? v.m1_we  : v.m0_we;
    m0_we = v.m0_we; m0_sel = v.m0_sel; m0_di = v.m0_di;
    m1_we = v.m1_we; m1_sel = v.m1_sel; m1_di = v.m1_di;
    m0_stb = v.req[0];
    m1_stb = v.req[1];
    #1;
    check("idle_state", 64'(fsm_state), 64'(IDLE));
    check("idle_s_stb", 64'(s_stb), 64'd0);
    check("idle_s_sel", 64'(s_sel), 64'd0);
    check("idle_s_di", s_di, 64'd0);
    @(posedge sys_clk); #1;
    check("cmd_state", 64'(fsm_state), 64'(CMD));
    check("cmd_s_stb", 64'(s_stb), 64'd1);
    check("cmd_s_adr", 64'(s_adr), 64'(e_adr));
    check("cmd_s_we", 64'(s_we), 64'(e_we));
    for (int i = 0; i < v.dly; i++) begin
      check("cmd_wait_eack", 64'({m1_eack, m0_eack}), 64'd0);
      @(posedge sys_clk); #1;
    end
    s_eack = 1'b1;
    #1;
    check("eack_route", 64'({m1_eack, m0_eack}), v.exp_g ? 64'd2 : 64'd1);
    check("cmd_s_sel", 64'(s_sel), 64'(e_sel));
    check("cmd_s_di", s_di, e_di);
    if (v.exp_g) exp_g1 = (exp_g1 < 65535) ? exp_g1 + 1 : exp_g1;
    else         exp_g0 = (exp_g0 < 65535) ? exp_g0 + 1 : exp_g0;
    @(posedge sys_clk); #1;
    s_eack = 1'b0;
    if (v.exp_g) m1_stb = 1'b0;
    else         m0_stb = 1'b0;
  endtask

  task automatic do_data(input vec_t v, input int n);
    for (int k = 0; k < n; k++) begin
      s_do = {32'h5A5A_0000, 32'(k)};
      #1;
      check("data_state", 64'(fsm_state), 64'(DATA));
      check("data_s_stb", 64'(s_stb), 64'd0);
      check("data_s_sel", 64'(s_sel), 64'(v.exp_g ? v.m1_sel : v.m0_sel));
      check("data_s_di", s_di, v.exp_g ? v.m1_di : v.m0_di);
      check("data_do_bcast", m0_do ^ m1_do ^ s_do, {32'h5A5A_0000, 32'(k)});
      @(posedge sys_clk); #1;
    end
  endtask

  task automatic do_txn(input vec_t v);
    do_cmd(v);
    do_data(v, DC);
    check("back_to_idle", 64'(fsm_state), 64'(IDLE));
  endtask

  initial begin
    // v0..v3: tie after reset then sustained contention -> m0, m1, m0, m1
    vecs[0] = mk(2'b11, 1'b0, 1);
    vecs[1] = mk(2'b11, 1'b1, 0);
    vecs[2] = mk(2'b11, 1'b0, 3);
    vecs[3] = mk(2'b11, 1'b1, 2);
    vecs[4] = mk(2'b01, 1'b0, 2);
    vecs[5] = '{2'b10, 1'b1, 1'b0, 8'h00, 64'h0, 1'b1, 8'h0F, 64'hDEADBEEF_CAFEF00D, 1};
    vecs[6] = mk(2'b10, 1'b1, 0);
    vecs[7] = mk(2'b11, 1'b0, 1);
    vecs[8] = '{2'b01, 1'b0, 1'b1, 8'hFF, 64'h0123_4567_89AB_CDEF, 1'b0, 8'h3C, 64'h1111, 0};
    vecs[9] = '{2'b11, 1'b1, 1'b1, 8'hA5, 64'hFFFF_0000, 1'b1, 8'hC3, 64'h0BAD_F00D_0000_7777, 2};

    // reset state, with master 0 actively requesting
    m0_stb = 1'b1; m0_we = 1'b1; m0_sel = 8'hFF; m0_di = 64'h1234;
    #2;
    check("rst_state", 64'(fsm_state), 64'(IDLE));
    check("rst_s_stb", 64'(s_stb), 64'd0);
    check("rst_s_adr", 64'(s_adr), 64'd0);
    check("rst_s_we", 64'(s_we), 64'd0);
    check("rst_s_sel", 64'(s_sel), 64'd0);
    check("rst_s_di", s_di, 64'd0);
    check("rst_eacks", 64'({m1_eack, m0_eack}), 64'd0);
    repeat (2) @(posedge sys_clk);
    #1;
    m0_stb = 1'b0;
    sys_rst = 1'b0;
    @(posedge sys_clk); #1;

    for (int i = 0; i < 10; i++) do_txn(vecs[i]);

    // granted master withdraws mid-command: abandoned, fairness pointer untouched (last = m1)
    m0_stb = 1'b1; m1_stb = 1'b0;
    @(posedge sys_clk); #1;
    check("viol_cmd_stb", 64'(s_stb), 64'd1);
    m0_stb = 1'b0;
    #1;
    check("viol_stb_drop", 64'(s_stb), 64'd0);
    @(posedge sys_clk); #1;
    check("viol_idle", 64'(fsm_state), 64'(IDLE));
    do_txn(mk(2'b11, 1'b0, 1));

    // async reset during DATA of an m0 write (last = m0 before reset)
    do_cmd('{2'b01, 1'b0, 1'b1, 8'hFF, 64'hAAAA_5555, 1'b0, 8'h00, 64'h0, 1});
    do_data('{2'b01, 1'b0, 1'b1, 8'hFF, 64'hAAAA_5555, 1'b0, 8'h00, 64'h0, 1}, 3);
    m1_stb = 1'b1;
    #2;
    s_eack = 1'b1;
    sys_rst = 1'b1;
    #1;
    check("mrst_state", 64'(fsm_state), 64'(IDLE));
    check("mrst_s_stb", 64'(s_stb), 64'd0);
    check("mrst_eacks", 64'({m1_eack, m0_eack}), 64'd0);
    check("mrst_s_sel", 64'(s_sel), 64'd0);
    check("mrst_s_di", s_di, 64'd0);
    s_eack = 1'b0;
    m1_stb = 1'b0;
    exp_g0 = 0;
    exp_g1 = 0;
    @(posedge sys_clk); #1;
    sys_rst = 1'b0;
    @(posedge sys_clk); #1;

    // tie after reset goes to m0 again; then a mix giving 3 m0 and 2 m1 grants
    do_txn(mk(2'b11, 1'b0, 2));
    do_txn(mk(2'b11, 1'b1, 1));
    do_txn(mk(2'b01, 1'b0, 0));
    do_txn(mk(2'b10, 1'b1, 1));
    do_txn(mk(2'b01, 1'b0, 2));

`ifdef FML_ARB2_STATS_EN
    check("stats_m0", 64'(m0_grants), 64'(exp_g0));
    check("stats_m1", 64'(m1_grants), 64'(exp_g1));
    force dut.m0_cnt = 16'hFFFF;
    @(posedge sys_clk); #1;
    release dut.m0_cnt;
    exp_g0 = 65535;
    do_txn(mk(2'b01, 1'b0, 1));
    check("stats_m0_sat", 64'(m0_grants), 64'(exp_g0));
    check("stats_m1_hold", 64'(m1_grants), 64'(exp_g1));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
